// File: rtl/sd_fifo_sync_s.sv
`default_nettype none
// ============================================================================
// sd_fifo_sync_s : single-clock srdy/drdy FIFO, registered read port, depth+1
//                  words. Optional occupancy port guarded by SD_FIFO_USAGE_EN.
// Revision: 1.0
// ============================================================================

module sd_fifo_sync_s_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ASZ   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ASZ-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ASZ-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Array is deliberately left without reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

module sd_fifo_sync_s_head #(
  parameter int ASZ = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c_srdy,
  input  logic [ASZ:0] rdptr,
  output logic         c_drdy,
  output logic         wr_en,
  output logic [ASZ:0] wrptr
);

  localparam logic [ASZ:0] c_ptr_one = {{ASZ{1'b0}}, 1'b1};

  logic [ASZ:0] wrptr_d;
  logic [ASZ:0] wrptr_q;
  logic         full;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign full   = (wrptr_q[ASZ-1:0] == rdptr[ASZ-1:0]) && (wrptr_q[ASZ] != rdptr[ASZ]);
  assign c_drdy = !full;
  assign wr_en  = c_srdy & c_drdy;

  always_comb begin
    wrptr_d = wrptr_q;
    if (wr_en) begin
      wrptr_d = wrptr_q + c_ptr_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrptr_q <= '0;
    end else begin
      wrptr_q <= wrptr_d;
    end
  end

  assign wrptr = wrptr_q;

endmodule

module sd_fifo_sync_s_tail #(
  parameter int ASZ = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [ASZ:0] wrptr,
  input  logic         p_drdy,
  output logic         rd_en,
  output logic [ASZ:0] rdptr,
  output logic         p_srdy
);

  localparam logic [ASZ:0] c_ptr_one = {{ASZ{1'b0}}, 1'b1};

  logic [ASZ:0] rdptr_d;
  logic [ASZ:0] rdptr_q;
  logic         p_srdy_d;
  logic         p_srdy_q;
  logic         empty;

  assign empty = (wrptr == rdptr_q);
  // Refill the output register whenever it is vacant or being drained.
  assign rd_en = !empty & (!p_srdy_q | p_drdy);

  always_comb begin
    rdptr_d  = rdptr_q;
    p_srdy_d = p_srdy_q;
    if (rd_en) begin
      rdptr_d  = rdptr_q + c_ptr_one;
      p_srdy_d = 1'b1;
    end else if (p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdptr_q  <= '0;
      p_srdy_q <= 1'b0;
    end else begin
      rdptr_q  <= rdptr_d;
      p_srdy_q <= p_srdy_d;
    end
  end

  assign rdptr  = rdptr_q;
  assign p_srdy = p_srdy_q;

endmodule

module sd_fifo_sync_s #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     c_srdy,
  output logic                     c_drdy,
  input  logic [WIDTH-1:0]         c_data,
  output logic                     p_srdy,
  input  logic                     p_drdy,
  output logic [WIDTH-1:0]         p_data
`ifdef SD_FIFO_USAGE_EN
  ,
  output logic [$clog2(DEPTH):0]   usage
`endif
);

  localparam int ASZ = $clog2(DEPTH);

  logic         wr_en;
  logic         rd_en;
  logic [ASZ:0] wrptr;
  logic [ASZ:0] rdptr;

  sd_fifo_sync_s_head #(
    .ASZ     (ASZ)
  ) u_head (
    .clk     (clk),
    .reset   (reset),
    .c_srdy  (c_srdy),
    .rdptr   (rdptr),
    .c_drdy  (c_drdy),
    .wr_en   (wr_en),
    .wrptr   (wrptr)
  );

  sd_fifo_sync_s_tail #(
    .ASZ     (ASZ)
  ) u_tail (
    .clk     (clk),
    .reset   (reset),
    .wrptr   (wrptr),
    .p_drdy  (p_drdy),
    .rd_en   (rd_en),
    .rdptr   (rdptr),
    .p_srdy  (p_srdy)
  );

  sd_fifo_sync_s_mem #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ASZ     (ASZ)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wrptr[ASZ-1:0]),
    .wr_data (c_data),
    .rd_en   (rd_en),
    .rd_addr (rdptr[ASZ-1:0]),
    .rd_data (p_data)
  );

`ifdef SD_FIFO_USAGE_EN
  // Words in the array plus the one parked in the output register.
  assign usage = (wrptr - rdptr) + {{ASZ{1'b0}}, p_srdy};
`else
  // Default build: no occupancy output.
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_fifo_sync_s.sv
`default_nettype none
// ============================================================================
// tb_sd_fifo_sync_s : randomized and directed bench for sd_fifo_sync_s with a
//                     queue-based reference model and an order scoreboard.
// Revision: 1.0
// ============================================================================
module tb_sd_fifo_sync_s;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int ASZ   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             c_srdy;
  logic             c_drdy;
  logic [WIDTH-1:0] c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [WIDTH-1:0] p_data;
`ifdef SD_FIFO_USAGE_EN
  logic [ASZ:0]     usage;
`endif

  sd_fifo_sync_s #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data)
`ifdef SD_FIFO_USAGE_EN
    ,
    .usage  (usage)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words waiting in the array, plus the output register.
  logic [WIDTH-1:0] m_mem [$];
  bit               m_valid;
  logic [WIDTH-1:0] m_data;

  // Scoreboard fed by observed DUT handshakes.
  logic [WIDTH-1:0] exp_q [$];
  int               n_acc;
  int               n_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reset  = 1'b1;
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    c_data = '0;
    #1;
    check("rst_c_drdy", {31'd0, c_drdy}, 32'd1);
    check("rst_p_srdy", {31'd0, p_srdy}, 32'd0);
    check("rst_p_data", {24'd0, p_data}, 32'd0);
    m_mem.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    n_acc   = 0;
    n_out   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cycle();
    bit               acc;
    bit               rd;
    bit               dut_acc;
    bit               dut_out;
    bit               hold;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] pd_before;
    acc       = c_srdy && (m_mem.size() < DEPTH);
    rd        = (m_mem.size() > 0) && (!m_valid || p_drdy);
    d         = c_data;
    dut_acc   = c_srdy && c_drdy;
    dut_out   = p_srdy && p_drdy;
    hold      = p_srdy && !p_drdy;
    pd_before = p_data;
    @(posedge clk);
    #1;
    if (rd) begin
      m_data  = m_mem.pop_front();
      m_valid = 1'b1;
    end else if (p_drdy) begin
      m_valid = 1'b0;
    end
    if (acc) m_mem.push_back(d);
    if (dut_acc) begin
      exp_q.push_back(d);
      n_acc++;
    end
    if (dut_out) begin
      n_out++;
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("sb_order", {24'd0, pd_before}, {24'd0, exp_q.pop_front()});
    end
    if (hold) check("p_data_hold", {24'd0, p_data}, {24'd0, pd_before});
    check("m_c_drdy", {31'd0, c_drdy}, {31'd0, (m_mem.size() < DEPTH)});
    check("m_p_srdy", {31'd0, p_srdy}, {31'd0, m_valid});
    check("m_p_data", {24'd0, p_data}, {24'd0, m_data});
`ifdef SD_FIFO_USAGE_EN
    check("m_usage", {29'd0, usage}, m_mem.size() + m_valid);
`endif
  endtask

  initial begin
    int cyc;
    reset  = 1'b0;
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    c_data = '0;

    // Reset and idle.
    do_reset();
    repeat (3) cycle();
    check("idle_c_drdy", {31'd0, c_drdy}, 32'd1);
    check("idle_p_srdy", {31'd0, p_srdy}, 32'd0);

    // Fill with the output blocked: depth+1 words fit.
    p_drdy = 1'b0;
    c_srdy = 1'b1;
    repeat (8) begin
      c_data = 8'(n_acc + 1);
      cycle();
    end
    check("fill_count", n_acc, 5);
    check("fill_c_drdy", {31'd0, c_drdy}, 32'd0);
    check("fill_p_srdy", {31'd0, p_srdy}, 32'd1);
    check("fill_p_data", {24'd0, p_data}, 32'h01);
`ifdef SD_FIFO_USAGE_EN
    check("fill_usage", {29'd0, usage}, 32'd5);
`endif

    // One drain pulse frees a slot for one more word.
    c_srdy = 1'b0;
    p_drdy = 1'b1;
    cycle();
    check("pulse_c_drdy", {31'd0, c_drdy}, 32'd1);
    p_drdy = 1'b0;
    c_srdy = 1'b1;
    c_data = 8'h06;
    cycle();
    check("pulse_extra_acc", n_acc, 6);
    c_srdy = 1'b0;
    p_drdy = 1'b1;
    repeat (8) cycle();
    check("pulse_drain_out", n_out, 6);

    // Single-word latency.
    do_reset();
    p_drdy = 1'b1;
    c_srdy = 1'b1;
    c_data = 8'hA5;
    cycle();
    c_srdy = 1'b0;
    check("lat_k_p_srdy", {31'd0, p_srdy}, 32'd0);
    cycle();
    check("lat_k1_p_srdy", {31'd0, p_srdy}, 32'd1);
    check("lat_k1_p_data", {24'd0, p_data}, 32'hA5);
    cycle();
    check("lat_k2_p_srdy", {31'd0, p_srdy}, 32'd0);

    // Streaming at full rate across several pointer wraps.
    do_reset();
    c_srdy = 1'b1;
    p_drdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c_data = 8'(8'h40 + i);
      check("stream_c_drdy", {31'd0, c_drdy}, 32'd1);
      cycle();
    end
    c_srdy = 1'b0;
    repeat (2) cycle();
    check("stream_acc", n_acc, 40);
    check("stream_out", n_out, 40);

    // Reset in the middle of traffic.
    c_srdy = 1'b1;
    p_drdy = 1'b0;
    repeat (3) begin
      c_data = 8'($urandom);
      cycle();
    end
    do_reset();

    // Randomized handshakes.
    cyc = 0;
    while (n_out < 1000 && cyc < 20000) begin
      c_srdy = 1'($urandom_range(0, 1));
      p_drdy = 1'($urandom_range(0, 1));
      c_data = 8'($urandom);
      cycle();
      cyc++;
    end
    check("rand_done", {31'd0, (n_out >= 1000)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
